// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM arbiter: FSM encodings, default SRAM widths, port ids.
package sram_pkg;

   localparam int unsigned SRAM_ADDR_W = 18;
   localparam int unsigned SRAM_DATA_W = 16;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } arb_state_e;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner selection between ports A and B.
// SRAM_ARB_ROUND_ROBIN_EN: on a tie the port not granted last wins; otherwise A has fixed priority.
module sram_arb_pick
   import sram_pkg::*;
(
   input  logic a_req,
   input  logic b_req,
   input  logic last_grant,
   output logic valid_c,
   output logic winner_c
);

`ifndef SRAM_ARB_ROUND_ROBIN_EN
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

   always_comb begin
      valid_c  = a_req | b_req;
      winner_c = PORT_A;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      if (a_req && b_req) begin
         winner_c = ~last_grant;
      end else if (b_req) begin
         winner_c = PORT_B;
      end
`else
      if (!a_req && b_req) begin
         winner_c = PORT_B;
      end
`endif
   end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of SRAM_Controller: latches the winning command, holds it for
// ACCESS_CYCLES, then acks. Build with SRAM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking.
module sram_arbiter
   import sram_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH    = SRAM_ADDR_W,
   parameter int unsigned DATA_WIDTH    = SRAM_DATA_W,
   parameter int unsigned ACCESS_CYCLES = 4
) (
   input  logic                  CLK,
   input  logic                  RSTX,
   input  logic                  A_REQ,
   input  logic                  A_WE,
   input  logic [ADDR_WIDTH-1:0] A_ADDR,
   input  logic [DATA_WIDTH-1:0] A_WDATA,
   output logic                  A_ACK,
   output logic [DATA_WIDTH-1:0] A_RDATA,
   input  logic                  B_REQ,
   input  logic                  B_WE,
   input  logic [ADDR_WIDTH-1:0] B_ADDR,
   input  logic [DATA_WIDTH-1:0] B_WDATA,
   output logic                  B_ACK,
   output logic [DATA_WIDTH-1:0] B_RDATA,
   output logic                  MEM_WE,
   output logic [ADDR_WIDTH-1:0] MEM_ADDR,
   output logic [DATA_WIDTH-1:0] MEM_WDATA,
   input  logic [DATA_WIDTH-1:0] MEM_RDATA,
   output logic                  GRANT,
   output logic                  BUSY
);

   localparam int unsigned      CNT_W    = 4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

   arb_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  grant_q, grant_d;
   logic                  busy_q, busy_d;
   logic                  cmd_we_q, cmd_we_d;
   logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
   logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic                  a_ack_q, a_ack_d;
   logic                  b_ack_q, b_ack_d;
   logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
   logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
   logic                  req_valid;
   logic                  req_winner;

   sram_arb_pick u_pick (
      .a_req      (A_REQ),
      .b_req      (B_REQ),
      .last_grant (grant_q),
      .valid_c    (req_valid),
      .winner_c   (req_winner)
   );

   // Next-state, command latch and output computation
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      grant_d     = grant_q;
      cmd_we_d    = cmd_we_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_wdata_d = cmd_wdata_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      a_ack_d     = 1'b0;
      b_ack_d     = 1'b0;
      a_rdata_d   = a_rdata_q;
      b_rdata_d   = b_rdata_q;

      case (state_q)
         IDLE: begin
            mem_we_d = 1'b0;
            if (req_valid) begin
               grant_d = req_winner;
               if (req_winner == PORT_B) begin
                  cmd_we_d    = B_WE;
                  cmd_addr_d  = B_ADDR;
                  cmd_wdata_d = B_WDATA;
               end else begin
                  cmd_we_d    = A_WE;
                  cmd_addr_d  = A_ADDR;
                  cmd_wdata_d = A_WDATA;
               end
               state_d = SETUP;
            end
         end
         SETUP: begin
            mem_we_d    = cmd_we_q;
            mem_addr_d  = cmd_addr_q;
            mem_wdata_d = cmd_wdata_q;
            cnt_d       = '0;
            state_d     = ACCESS;
         end
         ACCESS: begin
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            mem_we_d = 1'b0;
            if (grant_q == PORT_B) begin
               b_ack_d = 1'b1;
               if (!cmd_we_q) b_rdata_d = MEM_RDATA;
            end else begin
               a_ack_d = 1'b1;
               if (!cmd_we_q) a_rdata_d = MEM_RDATA;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK or negedge RSTX) begin
      if (!RSTX) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         grant_q     <= PORT_A;
         busy_q      <= 1'b0;
         cmd_we_q    <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         a_ack_q     <= 1'b0;
         b_ack_q     <= 1'b0;
         a_rdata_q   <= '0;
         b_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         grant_q     <= grant_d;
         busy_q      <= busy_d;
         cmd_we_q    <= cmd_we_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_wdata_q <= cmd_wdata_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         a_ack_q     <= a_ack_d;
         b_ack_q     <= b_ack_d;
         a_rdata_q   <= a_rdata_d;
         b_rdata_q   <= b_rdata_d;
      end
   end

   assign A_ACK     = a_ack_q;
   assign B_ACK     = b_ack_q;
   assign A_RDATA   = a_rdata_q;
   assign B_RDATA   = b_rdata_q;
   assign MEM_WE    = mem_we_q;
   assign MEM_ADDR  = mem_addr_q;
   assign MEM_WDATA = mem_wdata_q;
   assign GRANT     = grant_q;
   assign BUSY      = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one instance at ACCESS_CYCLES=4, one at ACCESS_CYCLES=1.
module tb_sram_arbiter;
   import sram_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
   logic [17:0] a_addr = '0, b_addr = '0;
   logic [15:0] a_wdata = '0, b_wdata = '0;
   logic        a_ack, b_ack, mem_we, grant, busy;
   logic [15:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
   logic [17:0] mem_addr;

   logic        a1_req = 0;
   logic [17:0] a1_addr = '0;
   logic        a1_ack, b1_ack, m1_we, grant1, busy1;
   logic [15:0] a1_rdata, b1_rdata, m1_wdata, m1_rdata;
   logic [17:0] m1_addr;

   int n_cmp = 0;
   int n_err = 0;

   sram_arbiter #(.ADDR_WIDTH(18), .DATA_WIDTH(16), .ACCESS_CYCLES(4)) dut (
      .CLK(clk), .RSTX(rst_n),
      .A_REQ(a_req), .A_WE(a_we), .A_ADDR(a_addr), .A_WDATA(a_wdata),
      .A_ACK(a_ack), .A_RDATA(a_rdata),
      .B_REQ(b_req), .B_WE(b_we), .B_ADDR(b_addr), .B_WDATA(b_wdata),
      .B_ACK(b_ack), .B_RDATA(b_rdata),
      .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata),
      .GRANT(grant), .BUSY(busy)
   );

   sram_arbiter #(.ADDR_WIDTH(18), .DATA_WIDTH(16), .ACCESS_CYCLES(1)) dut1 (
      .CLK(clk), .RSTX(rst_n),
      .A_REQ(a1_req), .A_WE(1'b0), .A_ADDR(a1_addr), .A_WDATA(16'h0000),
      .A_ACK(a1_ack), .A_RDATA(a1_rdata),
      .B_REQ(1'b0), .B_WE(1'b0), .B_ADDR(18'h00000), .B_WDATA(16'h0000),
      .B_ACK(b1_ack), .B_RDATA(b1_rdata),
      .MEM_WE(m1_we), .MEM_ADDR(m1_addr), .MEM_WDATA(m1_wdata), .MEM_RDATA(m1_rdata),
      .GRANT(grant1), .BUSY(busy1)
   );

   // 16-word SRAM model (low address nibble), preset to C000+index on reset
   logic [15:0] mem [16];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) mem[i] <= 16'hC000 | 16'(i);
      end else if (mem_we) begin
         mem[mem_addr[3:0]] <= mem_wdata;
      end
   end
   assign mem_rdata = mem[mem_addr[3:0]];
   assign m1_rdata  = m1_addr[15:0] ^ 16'h5A5A;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request, drop it in the ACK cycle; k counts samples after the grant edge
   task automatic txn(input logic port, input logic we, input logic [17:0] addr,
                      input logic [15:0] wd, output int ack_at, output int acks,
                      output int we_cyc, output int other, output logic [15:0] rd);
      ack_at = -1; acks = 0; we_cyc = 0; other = 0; rd = '0;
      if (port == PORT_A) begin
         a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
      end else begin
         b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
      end
      for (int k = 0; k < 16; k++) begin
         tick();
         if (mem_we && mem_addr == addr && mem_wdata == wd) we_cyc++;
         if ((port == PORT_A) ? b_ack : a_ack) other++;
         if ((port == PORT_A) ? a_ack : b_ack) begin
            acks++;
            if (ack_at < 0) begin
               ack_at = k;
               rd = (port == PORT_A) ? a_rdata : b_rdata;
            end
            if (port == PORT_A) a_req = 1'b0;
            else b_req = 1'b0;
         end
      end
   endtask

   int          ack_at, acks, we_cyc, other, nacks, cnt, bad, first, last, busy_cyc, bad_addr;
   logic [15:0] rd;
   logic [3:0]  gseq;
   logic        ord [4];
   logic        gr [4];
   int          at [4];

   initial begin
      #3 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_mem_we", 32'(mem_we), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_grant", 32'(grant), 0);
      check_eq("rst_a_ack", 32'(a_ack), 0);
      check_eq("rst_a_rdata", 32'(a_rdata), 0);
      rst_n = 1'b1;
      tick(); tick();

      // 1: A write
      txn(PORT_A, 1'b1, 18'h00000, 16'hAAAA, ack_at, acks, we_cyc, other, rd);
      check_eq("t1_ack_at", 32'(ack_at), 6);
      check_eq("t1_acks", 32'(acks), 1);
      check_eq("t1_we_cycles", 32'(we_cyc), 5);
      check_eq("t1_b_ack", 32'(other), 0);
      check_eq("t1_mem0", 32'(mem[0]), 32'hAAAA);
      check_eq("t1_busy_end", 32'(busy), 0);

      // 2: A read of the written word
      txn(PORT_A, 1'b0, 18'h00000, 16'h0000, ack_at, acks, we_cyc, other, rd);
      check_eq("t2_ack_at", 32'(ack_at), 6);
      check_eq("t2_rdata_at_ack", 32'(rd), 32'hAAAA);
      check_eq("t2_mem_we", 32'(we_cyc), 0);
      repeat (3) tick();
      check_eq("t2_rdata_held", 32'(a_rdata), 32'hAAAA);

      // 3: simultaneous A read and B write
      a_req = 1'b1; a_we = 1'b0; a_addr = 18'h00000;
      b_req = 1'b1; b_we = 1'b1; b_addr = 18'h11111; b_wdata = 16'h5555;
      nacks = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (a_ack && nacks < 4) begin
            ord[nacks] = PORT_A; gr[nacks] = grant; at[nacks] = k; nacks++; a_req = 1'b0;
         end
         if (b_ack && nacks < 4) begin
            ord[nacks] = PORT_B; gr[nacks] = grant; at[nacks] = k; nacks++; b_req = 1'b0;
         end
      end
      check_eq("t3_nacks", 32'(nacks), 2);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      check_eq("t3_first_port", 32'(ord[0]), 1);
      check_eq("t3_first_grant", 32'(gr[0]), 1);
      check_eq("t3_second_port", 32'(ord[1]), 0);
      check_eq("t3_second_grant", 32'(gr[1]), 0);
`else
      check_eq("t3_first_port", 32'(ord[0]), 0);
      check_eq("t3_first_grant", 32'(gr[0]), 0);
      check_eq("t3_second_port", 32'(ord[1]), 1);
      check_eq("t3_second_grant", 32'(gr[1]), 1);
`endif
      check_eq("t3_first_at", 32'(at[0]), 6);
      check_eq("t3_second_at", 32'(at[1]), 13);
      check_eq("t3_mem1", 32'(mem[1]), 32'h5555);

      // 3b: both requests held continuously
      a_req = 1'b1; b_req = 1'b1;
      nacks = 0; gseq = '0; other = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (b_ack) other++;
         if ((a_ack || b_ack) && nacks < 4) begin
            gseq[nacks] = grant; at[nacks] = k; nacks++;
         end
      end
      a_req = 1'b0; b_req = 1'b0;
      repeat (14) tick();
      check_eq("t3b_nacks", 32'(nacks), 4);
      check_eq("t3b_last_at", 32'(at[3]), 27);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      check_eq("t3b_grant_seq", 32'(gseq), 32'h5);
      check_eq("t3b_b_acks", 32'(other), 2);
`else
      check_eq("t3b_grant_seq", 32'(gseq), 32'h0);
      check_eq("t3b_b_acks", 32'(other), 0);
`endif

      // 4: asynchronous reset in ACCESS of a B write
      b_req = 1'b1; b_we = 1'b1; b_addr = 18'h00002; b_wdata = 16'h1234;
      tick(); tick(); tick();
      check_eq("t4_pre_mem_we", 32'(mem_we), 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("t4_rst_mem_we", 32'(mem_we), 0);
      check_eq("t4_rst_busy", 32'(busy), 0);
      check_eq("t4_rst_acks", 32'({a_ack, b_ack}), 0);
      b_req = 1'b0;
      other = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (b_ack || busy) other++;
      end
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (b_ack || busy) other++;
      end
      check_eq("t4_no_ack_idle", 32'(other), 0);
      txn(PORT_B, 1'b1, 18'h00002, 16'h1234, ack_at, acks, we_cyc, other, rd);
      check_eq("t4_reissue_ack_at", 32'(ack_at), 6);
      check_eq("t4_reissue_we", 32'(we_cyc), 5);
      check_eq("t4_mem2", 32'(mem[2]), 32'h1234);
      check_eq("t4_b_rdata", 32'(b_rdata), 0);

      // 5: A read, REQ dropped and address changed right after grant
      a_req = 1'b1; a_we = 1'b0; a_addr = 18'h00005;
      tick();
      a_req = 1'b0; a_addr = 18'h3FFFF;
      acks = 0; busy_cyc = 0; bad_addr = 0;
      for (int k = 1; k < 16; k++) begin
         tick();
         if (a_ack) acks++;
         if (busy) busy_cyc++;
         if (mem_addr == 18'h3FFFF) bad_addr++;
      end
      check_eq("t5_acks", 32'(acks), 1);
      check_eq("t5_busy_cycles", 32'(busy_cyc), 5);
      check_eq("t5_bad_addr", 32'(bad_addr), 0);
      check_eq("t5_mem_addr", 32'(mem_addr), 32'h5);
      check_eq("t5_rdata", 32'(a_rdata), 32'hC005);

      // 6: ACCESS_CYCLES=1, back-to-back A reads with REQ held
      a1_req = 1'b1; a1_addr = 18'h00012;
      cnt = 0; bad = 0; first = -1; last = -1; we_cyc = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (m1_we) we_cyc++;
         if (a1_ack) begin
            if (last >= 0 && (k - last) != 4) bad++;
            if (first < 0) first = k;
            last = k;
            cnt++;
         end
      end
      a1_req = 1'b0;
      repeat (6) tick();
      check_eq("t6_first_ack", 32'(first), 3);
      check_eq("t6_ack_count", 32'(cnt), 5);
      check_eq("t6_bad_gap", 32'(bad), 0);
      check_eq("t6_mem_we", 32'(we_cyc), 0);
      check_eq("t6_rdata", 32'(a1_rdata), 32'h5A48);
      check_eq("t6_busy_end", 32'(busy1), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
